pru_draw_scheduler: RTL
=======================

// Module: pru_draw_scheduler
// PURPOSE
//  Arbitrates draw commands from two requesters (CPU MMIO port, sprite engine) into a command queue.
//  Sequences the PRU start/done handshake, one command at a time.
//  Sits between the bus/sprite logic and the PRU draw inputs; the PRU is never driven directly by requesters.
//  Provides queue status and a sticky watchdog error to software.
// PARAMETERS
//  DEPTH        4      command queue entries (power of 2, >=2)
//  TIMEOUT_CYC  1<<20  max clk cycles from pru_start rise to pru_done=1 before abort
// PORTS
//  clk               in   1      clock
//  rst_n             in   1      reset, asynchronous, active-low
//  cpu_valid         in   1      CPU command valid
//  cpu_ready         out  1      CPU command accepted this cycle (valid&ready)
//  cpu_cmd           in   43     packed pru_cmd_t
//  spr_valid         in   1      sprite-engine command valid
//  spr_ready         out  1      sprite command accepted this cycle
//  spr_cmd           in   43     packed pru_cmd_t
//  flush             in   1      discard all queued (not in-flight) commands
//  err_clr           in   1      clear err_timeout
//  pru_color         out  2      to PRU color
//  pru_col           out  10     to PRU col
//  pru_row           out  9      to PRU row
//  pru_width         out  10     to PRU width
//  pru_height_radius out  9      to PRU height_radius
//  pru_shape_select  out  2      00 rect, 01 circle, 1x bitmap
//  pru_subtract      out  1      to PRU subtract
//  pru_start         out  1      to PRU start (level, held until done)
//  pru_busy          in   1      from PRU
//  pru_done          in   1      from PRU (registered; high in COMPLETE until start drops)
//  q_level           out  $clog2(DEPTH)+1  queued entry count
//  sched_idle        out  1      queue empty and FSM in S_IDLE
//  err_timeout       out  1      sticky watchdog flag
// BEHAVIOUR
//  Reset: all outputs 0 except sched_idle=1; queue empty; FSM S_IDLE; rr pointer favours CPU first.
//  pru_cmd_t {color[42:41], col[40:31], row[30:22], width[21:12], height_radius[11:3], shape[2:1], subtract[0]}.
//  Arbiter: ready only when queue not full and not flush. One push per cycle.
//   Both valid -> grant the requester not granted last; the pointer updates only on an actual grant.
//   A requester alone wins regardless of the pointer.
//  Queue push and pop in the same cycle are legal at any level.
//   At full, ready=0 even if a pop occurs (no pass-through).
//  flush: the queue empties on the next edge; it has priority over a same-cycle push (push dropped, ready=0).
//   The in-flight command is unaffected.
//  FSM:
//   S_IDLE: if queue non-empty, pop and register the fields onto pru_* outputs -> S_ISSUE.
//   S_ISSUE: pru_start=1; watchdog counts. pru_done=1 -> S_RELEASE.
//    Counter reaching TIMEOUT_CYC -> set err_timeout -> S_RELEASE.
//   S_RELEASE: pru_start=0; wait pru_done=0 (and pru_busy=0) -> S_IDLE.
//  Latency: the push edge is N. Pop occurs at N+1 (FSM samples non-empty after N).
//   pru_start=1 is first visible after edge N+2. Field outputs are stable from the pop until the next pop.
//  Minimum gap between commands: pru_start is low for >=1 cycle between commands. Back-to-back issue with start held high is forbidden.
//  Watchdog counter: width $clog2(TIMEOUT_CYC)+1, cleared on entry to S_ISSUE, saturating.
//  err_timeout is sticky; err_clr clears it. If a timeout and err_clr coincide, set wins.
//  Reset mid-operation: pru_start drops asynchronously with rst_n, and the queue is lost.
// STRUCTURE
//  pru_pkg: pru_cmd_t packed struct, shape_e enum (RECT/CIRCLE/BITMAP), sched_state_e enum, CMD_W=43.
//  Sub-module pru_cmd_fifo: sync FIFO, DEPTH x CMD_W, push/pop/flush, full/empty/level.
//  Arbiter, FSM and watchdog stay in this module.
// TESTING
//  1 CPU pushes rect {c=1,col=10,row=20,w=5,h=3}: pru_start rises 2 edges after accept; fields match; start falls 1 cycle after pru_done=1.
//  2 cpu_valid and spr_valid held high for 4 accepts: grant order CPU,SPR,CPU,SPR.
//  3 Push 5 commands with PRU stalled, DEPTH=4: 1 in flight, 4 queued; q_level=4; both readys 0 until next pop.
//  4 Queue 3 commands, assert flush during the 1st draw: 1st completes, q_level=0, no further pru_start, sched_idle=1.
//  5 TIMEOUT_CYC=16, PRU never sets done: err_timeout=1 at 16 cycles, start drops, next command issues; err_clr clears it.
//  6 Assert rst_n=0 while pru_start=1: all outputs are at reset values immediately, and no start follows reset until a new push.

Source files
------------

// File: rtl/pru_pkg.sv
// Shared types for the PRU draw scheduler: command layout, shape codes and FSM states.
package pru_pkg;

  localparam int CMD_W = 43;

  // Shape codes as seen on pru_shape_select; any code with bit 1 set selects a bitmap.
  typedef enum logic [1:0] {
    SHAPE_RECT   = 2'b00,
    SHAPE_CIRCLE = 2'b01,
    SHAPE_BITMAP = 2'b10
  } shape_e;

  // One draw command exactly as it travels from a requester to the PRU.
  typedef struct packed {
    logic [1:0] color;
    logic [9:0] col;
    logic [8:0] row;
    logic [9:0] width;
    logic [8:0] height_radius;
    logic [1:0] shape;
    logic       subtract;
  } pru_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pru_draw_scheduler_if.sv
// Requester-side and PRU-side signals of the draw scheduler bundled into one interface.
interface pru_draw_scheduler_if;
  import pru_pkg::*;

  logic       cpu_valid;
  logic       cpu_ready;
  pru_cmd_t   cpu_cmd;
  logic       spr_valid;
  logic       spr_ready;
  pru_cmd_t   spr_cmd;

  logic [1:0] pru_color;
  logic [9:0] pru_col;
  logic [8:0] pru_row;
  logic [9:0] pru_width;
  logic [8:0] pru_height_radius;
  logic [1:0] pru_shape_select;
  logic       pru_subtract;
  logic       pru_start;
  logic       pru_busy;
  logic       pru_done;

  // Environment view: requesters and the PRU itself.
  modport master (
    output cpu_valid, cpu_cmd, spr_valid, spr_cmd, pru_busy, pru_done,
    input  cpu_ready, spr_ready, pru_color, pru_col, pru_row, pru_width,
           pru_height_radius, pru_shape_select, pru_subtract, pru_start
  );

  // Scheduler view.
  modport slave (
    input  cpu_valid, cpu_cmd, spr_valid, spr_cmd, pru_busy, pru_done,
    output cpu_ready, spr_ready, pru_color, pru_col, pru_row, pru_width,
           pru_height_radius, pru_shape_select, pru_subtract, pru_start
  );

endinterface

// File: rtl/pru_cmd_fifo.sv
// Synchronous command FIFO with push, pop, whole-queue flush and level reporting.
module pru_cmd_fifo
  import pru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  pru_cmd_t               wdata_i,
  output pru_cmd_t               rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  pru_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Storage array; contents need no reset because the count guards every read.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pru_draw_scheduler.sv
// Round-robin arbitration of CPU and sprite draw commands into a queue, and a
// start/done sequencer with watchdog that feeds one command at a time to the PRU.
module pru_draw_scheduler
  import pru_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pru_draw_scheduler_if.slave    bus,
  input  logic                   flush_i,
  input  logic                   err_clr_i,
  output logic [$clog2(DEPTH):0] q_level_o,
  output logic                   sched_idle_o,
  output logic                   err_timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX   = '1;

  sched_state_e    state_q, state_d;
  pru_cmd_t        cmd_q;
  pru_cmd_t        headCmd;
  pru_cmd_t        pushCmd;
  logic            start_q, start_d;
  logic            lastSpr_q;
  logic            errTimeout_q;
  logic [WD_W-1:0] wdCnt_q;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            canPush;
  logic            grantCpu;
  logic            grantSpr;
  logic            popEn;
  logic            timeoutHit;

  // A requester alone always wins; on contention the one not granted last wins.
  assign canPush  = !fifoFull && !flush_i;
  assign grantCpu = canPush && bus.cpu_valid && (!bus.spr_valid || lastSpr_q);
  assign grantSpr = canPush && bus.spr_valid && (!bus.cpu_valid || !lastSpr_q);
  assign pushCmd  = grantCpu ? bus.cpu_cmd : bus.spr_cmd;

  assign bus.cpu_ready = grantCpu;
  assign bus.spr_ready = grantSpr;

  pru_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grantCpu || grantSpr),
    .pop_i   (popEn),
    .flush_i (flush_i),
    .wdata_i (pushCmd),
    .rdata_o (headCmd),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (q_level_o)
  );

  // Round-robin pointer; reset value makes the CPU the first winner on contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lastSpr_q <= 1'b1;
    else if (grantCpu) lastSpr_q <= 1'b0;
    else if (grantSpr) lastSpr_q <= 1'b1;
  end

  // Next-state logic; start is registered so it rises one edge after entering S_ISSUE
  // and drops on the same edge that leaves S_ISSUE.
  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    popEn      = 1'b0;
    timeoutHit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifoEmpty && !flush_i) begin
          popEn   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.pru_done) begin
          state_d = S_RELEASE;
        end else if (wdCnt_q == WD_LIMIT) begin
          timeoutHit = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          start_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!bus.pru_done && !bus.pru_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, start and the latched command; reset drops start asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      if (popEn) cmd_q <= headCmd;
    end
  end

  // Watchdog cleared when a command is popped, then saturating count while issuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          wdCnt_q <= '0;
    else if (popEn)                                      wdCnt_q <= '0;
    else if (state_q == S_ISSUE && wdCnt_q != WD_MAX)    wdCnt_q <= wdCnt_q + WD_W'(1);
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         errTimeout_q <= 1'b0;
    else if (timeoutHit) errTimeout_q <= 1'b1;
    else if (err_clr_i)  errTimeout_q <= 1'b0;
  end

  assign bus.pru_color         = cmd_q.color;
  assign bus.pru_col           = cmd_q.col;
  assign bus.pru_row           = cmd_q.row;
  assign bus.pru_width         = cmd_q.width;
  assign bus.pru_height_radius = cmd_q.height_radius;
  assign bus.pru_shape_select  = cmd_q.shape;
  assign bus.pru_subtract      = cmd_q.subtract;
  assign bus.pru_start         = start_q;

  assign sched_idle_o  = fifoEmpty && (state_q == S_IDLE);
  assign err_timeout_o = errTimeout_q;

endmodule
